// File: rtl/mblight_ram_arbiter_if.sv
// Avalon-MM link shared by the requester ports and the RAM port of mblight_ram_arbiter.
// Requesters use master/slave; the RAM side uses mem_master/mem_slave.
interface mblight_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                chipselect;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

    modport mem_master (
        output address, byteenable, chipselect, write, writedata,
        input  readdata
    );

    modport mem_slave (
        input  address, byteenable, chipselect, write, writedata,
        output readdata
    );
endinterface

// File: rtl/mblight_ram_arbiter.sv
// Two-master arbiter in front of a 1-cycle-latency single-port RAM, with starvation guard.
// Define MBLIGHT_RAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise m0 has fixed priority.
module mblight_ram_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mblight_ram_arbiter_if.slave      m0,
    mblight_ram_arbiter_if.slave      m1,
    mblight_ram_arbiter_if.mem_master mem
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       w_req0, w_req1;
    logic       w_gnt0, w_gnt1;
    logic       w_rd_gnt;
    logic [3:0] w_starve0_nxt, w_starve1_nxt;
    logic [3:0] r_starve0, r_starve1;
    logic       r_rd_pend, r_rd_owner;
`ifdef MBLIGHT_RAM_ARB_ROUND_ROBIN_EN
    logic       r_last;
`endif

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    // Grants are held off while reset is low so the RAM sees no access.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n) begin
            if (w_req1 && (r_starve1 == LIMIT)) begin
                w_gnt1 = 1'b1;
            end else if (w_req0 && (r_starve0 == LIMIT)) begin
                w_gnt0 = 1'b1;
            end else if (w_req0 && w_req1) begin
`ifdef MBLIGHT_RAM_ARB_ROUND_ROBIN_EN
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
`else
                w_gnt0 = 1'b1;
`endif
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    function automatic logic [3:0] starve_next(input logic [3:0] cnt, input logic req,
                                               input logic gnt);
        if (!req || gnt) begin
            return 4'd0;
        end else if (cnt < LIMIT) begin
            return cnt + 4'd1;
        end
        return cnt;
    endfunction

    assign w_starve0_nxt = starve_next(r_starve0, w_req0, w_gnt0);
    assign w_starve1_nxt = starve_next(r_starve1, w_req1, w_gnt1);

    // A read+write request is a write; only pure reads return data.
    assign w_rd_gnt = (w_gnt0 & m0.read & ~m0.write) | (w_gnt1 & m1.read & ~m1.write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve0  <= 4'd0;
            r_starve1  <= 4'd0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
`ifdef MBLIGHT_RAM_ARB_ROUND_ROBIN_EN
            r_last     <= 1'b0;
`endif
        end else begin
            r_starve0  <= w_starve0_nxt;
            r_starve1  <= w_starve1_nxt;
            r_rd_pend  <= w_rd_gnt;
            r_rd_owner <= w_gnt1;
`ifdef MBLIGHT_RAM_ARB_ROUND_ROBIN_EN
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
`endif
        end
    end

    assign m0.waitrequest   = w_req0 & ~w_gnt0;
    assign m1.waitrequest   = w_req1 & ~w_gnt1;
    assign m0.readdata      = mem.readdata;
    assign m1.readdata      = mem.readdata;
    assign m0.readdatavalid = r_rd_pend & ~r_rd_owner;
    assign m1.readdatavalid = r_rd_pend & r_rd_owner;

    assign mem.address    = w_gnt1 ? m1.address    : m0.address;
    assign mem.byteenable = w_gnt1 ? m1.byteenable : m0.byteenable;
    assign mem.writedata  = w_gnt1 ? m1.writedata  : m0.writedata;
    assign mem.chipselect = w_gnt0 | w_gnt1;
    assign mem.write      = (w_gnt0 & m0.write) | (w_gnt1 & m1.write);

endmodule

// File: doc/mblight_ram_arbiter.md
# mblight_ram_arbiter

Two-requester Avalon-MM arbiter that shares the single-port 8192 x 32 on-chip RAM between the Nios II data master (m0) and the LED colour accumulator (m1). It sits between both masters and the RAM slave port and issues at most one access per cycle. It steers the 1-cycle-latency read data back to the owning master with a `readdatavalid` strobe. A starvation guard keeps the accumulator from being locked out by CPU traffic.

## Interface
Parameters:
- `ADDR_W`, 13, word address width (8192 words)
- `DATA_W`, 32, data width; byte lanes = DATA_W/8
- `STARVE_LIMIT`, 4, consecutive lost cycles before a waiting requester is forced to win (range 1..15)

Ports (`mN_*` exists for N = 0, 1):
- `clk`  in  1  single clock for all logic
- `reset_n`  in  1  asynchronous, active-low reset
- `mN_address`  in  ADDR_W  word address
- `mN_byteenable`  in  DATA_W/8  byte lanes for writes
- `mN_read`  in  1  read request
- `mN_write`  in  1  write request
- `mN_writedata`  in  DATA_W  write data
- `mN_waitrequest`  out  1  request not accepted this cycle
- `mN_readdata`  out  DATA_W  read data, valid only with `mN_readdatavalid`
- `mN_readdatavalid`  out  1  one-cycle strobe for returned read data
- `mem_address`  out  ADDR_W  RAM address
- `mem_byteenable`  out  DATA_W/8  RAM byte enables
- `mem_chipselect`  out  1  RAM access this cycle
- `mem_write`  out  1  RAM write
- `mem_writedata`  out  DATA_W  RAM write data
- `mem_readdata`  in  DATA_W  RAM output; unregistered, valid 1 cycle after address

## Operation
- Request of master N: `req_N = mN_read | mN_write`. If both read and write are asserted, the access is a write and no read data returns.
- Each cycle, at most one master is granted (`gnt_N`). `mN_waitrequest = req_N & ~gnt_N`. `mN_waitrequest` is 0 when idle.
- The granted master's address, byteenable, writedata and write drive the `mem_*` outputs. `mem_chipselect = gnt_0 | gnt_1`. With no grant, `mem_write = 0` and `mem_*` data outputs are don't-care.
- Grant policy is set by the configuration macro. The starvation override always applies on top of it.
- Starvation counters `starve_N` are 4-bit:
  - increment when `req_N & ~gnt_N`, saturating at `STARVE_LIMIT`;
  - clear when `gnt_N` or `~req_N`.
- When `starve_N == STARVE_LIMIT`, master N wins the next cycle it requests, regardless of policy. If both counters are at the limit, m1 wins.
- Read return: register `rd_pend` (1 bit) and `rd_owner` (1 bit), captured on every granted read.
  - In the next cycle, `mN_readdatavalid = rd_pend & (rd_owner == N)`.
  - Both `mN_readdata` outputs carry `mem_readdata` unconditionally.
- Back-to-back reads, including alternating owners, sustain one return per cycle. No skid buffer is needed because the RAM never stalls.

## Timing
- Cycle T: request asserted, granted combinationally, RAM address presented; `waitrequest = 0`.
- Cycle T+1: read data on `mN_readdata` with `mN_readdatavalid = 1`. Write is complete at the T to T+1 edge.
- Arbitration decision is combinational from `req_*`, the policy register and `starve_*`. The policy register and counters update on `clk` rising edge.
- Reset (`reset_n` low, asynchronous):
  - `rd_pend`, both `readdatavalid` outputs, `starve_*` and the last-grant pointer clear to 0 (pointer = m0).
  - `mem_chipselect` and `mem_write` are forced to 0 while `reset_n` is low.
  - `waitrequest` is forced to 1 for any requesting master.
- Reset asserted with a read outstanding: the returned data is dropped and no `readdatavalid` is issued after reset release.
- Simultaneous requests: resolved per policy. The loser sees `waitrequest = 1` and must hold its request stable.

## Configuration
- `MBLIGHT_RAM_ARB_ROUND_ROBIN_EN` defined:
  - round-robin policy; on contention, the master not granted last wins;
  - the last-grant pointer updates on every grant.
- Not defined:
  - fixed priority, m0 always wins on contention;
  - the pointer is unused;
  - m1 is protected only by the starvation override, so it waits at most `STARVE_LIMIT` cycles for a grant.

## Test plan
- Single reads: m0 reads addr 0x0010 (RAM = 0xDEADBEEF) → `mem_chipselect` in T, `m0_readdatavalid = 1` with 0xDEADBEEF in T+1, m1 strobe stays 0.
- Byte write: m1 writes 0xAABBCCDD with byteenable 0x4 to 0x1FFF, then m0 reads 0x1FFF → only byte 2 = 0xBB changed.
- Contention, macro undefined, STARVE_LIMIT = 4: both request continuously → m0 granted 4 cycles, m1 granted on 5th, pattern repeats; m1 `waitrequest` is never high for more than 4 consecutive cycles.
- Contention, macro defined: both request reads continuously → grants alternate m0, m1, m0, …; readdatavalid alternates accordingly with no gaps.
- Read+write both asserted on m0 → RAM written, no `m0_readdatavalid`.
- Reset mid-read: assert `reset_n` low in the cycle after a granted read → no `readdatavalid` after release; counters at 0; first contended grant goes to m1 when the macro is defined, to m0 otherwise.
